// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard bundle: decoded source/destination info in, pipeline control and
// operand-select out.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned RA_W = 5
);
  logic            id_valid;
  logic [RA_W-1:0] id_rs;
  logic [RA_W-1:0] id_rt;
  logic            id_use_rs;
  logic            id_use_rt;
  logic            id_wr;
  logic [RA_W-1:0] id_dst;
  logic            id_load;
  logic            id_branch;
  logic            br_taken;

  logic            pc_hold;
  logic            id_bubble;
  logic            if_flush;
  logic [2:0]      fwd_a;
  logic [2:0]      fwd_b;
  logic [15:0]     stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_dst, id_load, id_branch,
    output br_taken,
    input  pc_hold, id_bubble, if_flush, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr, id_dst, id_load, id_branch,
    input  br_taken,
    output pc_hold, id_bubble, if_flush, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: shift scoreboard of in-flight destinations after ID, RAW stall/forward
// decisions, and branch sequencing in freeze or predict-not-taken mode.
module pipe_hazard_ctrl #(
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned RA_W       = 5,
  parameter bit          FWD_EN     = 1'b0,
  parameter bit          BR_MODE    = 1'b0,
  parameter int unsigned BR_PENALTY = 3
) (
  input logic               clk,
  input logic               arst_n,
  pipe_hazard_ctrl_if.slave hz
);

  typedef struct packed {
    logic            v;
    logic [RA_W-1:0] dst;
    logic            load;
  } sb_entry_t;

  typedef enum logic [0:0] {StRun, StBrWait} state_e;

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  state_e                state_q;
  logic [2:0]            bc_q;
  logic [15:0]           stall_cnt_q;

  logic [DEPTH-1:0] match_a, match_b;
  logic [2:0]       youngest_a, youngest_b;
  logic             data_stall, in_br, squash, freeze, issue;
  logic             pc_hold, id_bubble;

  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      match_a[k] = hz.id_valid && hz.id_use_rs && (hz.id_rs != '0) && sb_q[k].v &&
                   (sb_q[k].dst == hz.id_rs);
      match_b[k] = hz.id_valid && hz.id_use_rt && (hz.id_rt != '0) && sb_q[k].v &&
                   (sb_q[k].dst == hz.id_rt);
    end
  end

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    youngest_a = 3'd0;
    youngest_b = 3'd0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (match_a[k]) youngest_a = 3'(k + 1);
      if (match_b[k]) youngest_b = 3'(k + 1);
    end
  end

  always_comb begin
    if (FWD_EN) data_stall = sb_q[0].load && (match_a[0] || match_b[0]);
    else        data_stall = (|match_a) || (|match_b);
  end

  assign in_br     = (state_q == StBrWait);
  assign squash    = BR_MODE && in_br && (bc_q == 3'd1) && hz.br_taken;
  assign freeze    = !BR_MODE && in_br;
  assign issue     = !in_br && hz.id_valid && hz.id_branch && !data_stall;
  assign pc_hold   = !squash && (freeze || data_stall);
  assign id_bubble = squash || (!freeze && data_stall);

  assign hz.pc_hold   = pc_hold;
  assign hz.id_bubble = id_bubble;
  assign hz.if_flush  = squash || freeze;
  assign hz.fwd_a     = (FWD_EN && !id_bubble) ? youngest_a : 3'd0;
  assign hz.fwd_b     = (FWD_EN && !id_bubble) ? youngest_b : 3'd0;
  assign hz.stall_cnt = stall_cnt_q;

  // On a squash, entries younger than the branch are killed as they shift.
  always_comb begin
    sb_d = sb_q;
    for (int k = 1; k < int'(DEPTH); k++) begin
      sb_d[k] = sb_q[k-1];
      if (squash && (k < int'(BR_PENALTY))) sb_d[k].v = 1'b0;
    end
    sb_d[0].v    = hz.id_valid && hz.id_wr && !id_bubble && (hz.id_dst != '0);
    sb_d[0].dst  = hz.id_dst;
    sb_d[0].load = hz.id_load;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sb_q        <= '0;
      state_q     <= StRun;
      bc_q        <= 3'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      sb_q <= sb_d;
      if (pc_hold && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      unique case (state_q)
        StRun: begin
          if (issue) begin
            state_q <= StBrWait;
            bc_q    <= 3'(BR_PENALTY);
          end
        end
        StBrWait: begin
          // A data stall freezes the countdown only when fetch is not already frozen.
          if (squash || ((bc_q == 3'd1) && (freeze || !data_stall))) begin
            state_q <= StRun;
            bc_q    <= 3'd0;
          end else if (freeze || !data_stall) begin
            bc_q <= bc_q - 3'd1;
          end
        end
        default: begin
          state_q <= StRun;
          bc_q    <= 3'd0;
        end
      endcase
    end
  end

endmodule
